// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM-download sequencer.
// Optional checksum output is enabled by defining ROM_DL_CHECKSUM_EN.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        RG_CPU = 1'b0,
        RG_SPR = 1'b1
    } region_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    // First ioctl byte address routed to the sprite port.
    localparam logic [24:0] SP_BASE_DEFAULT = 25'hA000;

    // Everything below the sprite base belongs to the CPU ROM port.
    function automatic region_t region_of(input logic [24:0] addr, input logic [24:0] base);
        return (addr < base) ? RG_CPU : RG_SPR;
    endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// Small synchronous FIFO of download entries. A push while full is accepted
// only when a pop happens in the same cycle (the freed slot is reused).
module rom_dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  dl_entry_t wr_data_i,
    input  logic      pop_i,
    output dl_entry_t rd_data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    dl_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           do_wr, do_rd;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == '0);
    assign do_rd     = pop_i && !empty_o;
    assign do_wr     = push_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Occupancy update for every push/pop combination.
    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array, no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes ioctl ROM-download bytes to the two SDRAM write ports with toggle
// req/ack handshakes, buffering bursts in rom_dl_fifo, and gates the CPU ROM
// ports (rom_hold) until the download has fully drained.
// Define ROM_DL_CHECKSUM_EN to add the dl_sum output (sum of issued bytes).
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [24:0] SP_BASE    = SP_BASE_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        rom_hold,
    output logic        rom_loaded,
    output logic        dl_overflow
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0] dl_sum
`endif
);

    // Input edge detection and capture stage
    logic      wr_q, downl_q, cap_valid_q;
    dl_entry_t cap_q;
    logic      wr_rise, dl_rise, dl_fall;

    // FSM and port registers
    state_t    state_q;
    dl_entry_t cur_q;
    region_t   rg_q, cur_rg;
    logic        p1_req_q, p2_req_q;
    logic [22:0] p1_a_q, p2_a_q;
    logic [1:0]  p1_ds_q, p2_ds_q;
    logic [15:0] p1_d_q, p2_d_q;

    // Completion / status
    logic hold_q, loaded_q, ovf_q, drain_q;

    // FIFO interface
    dl_entry_t fifo_head;
    logic      fifo_full, fifo_empty, pop;

    logic        ports_idle, issued_done, drained;
    logic [24:0] s;
    logic        unused_bits;

    assign wr_rise = ioctl_wr && !wr_q && ioctl_downl;
    assign dl_rise = ioctl_downl && !downl_q;
    assign dl_fall = !ioctl_downl && downl_q;

    assign ports_idle  = (p1_req_q == port1_ack) && (p2_req_q == port2_ack);
    assign pop         = (state_q == IDLE) && !fifo_empty && ports_idle;
    assign issued_done = (rg_q == RG_CPU) ? (p1_req_q == port1_ack) : (p2_req_q == port2_ack);
    // A byte still sitting in the capture stage counts as not drained.
    assign drained     = fifo_empty && !cap_valid_q && (state_q == IDLE) && ports_idle;

    // Sprite bytes are offset from the region base; only reached for addr >= SP_BASE.
    assign cur_rg      = region_of(cur_q.addr, SP_BASE);
    assign s           = cur_q.addr - SP_BASE;
    assign unused_bits = ^{s[24], cur_q.addr[24]};

    assign port1_req   = p1_req_q;
    assign port1_a     = p1_a_q;
    assign port1_ds    = p1_ds_q;
    assign port1_d     = p1_d_q;
    assign port2_req   = p2_req_q;
    assign port2_a     = p2_a_q;
    assign port2_ds    = p2_ds_q;
    assign port2_d     = p2_d_q;
    assign rom_hold    = hold_q;
    assign rom_loaded  = loaded_q;
    assign dl_overflow = ovf_q;

    // Edge detectors and one-entry capture of each strobed byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q        <= 1'b0;
            downl_q     <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_q       <= '0;
        end else begin
            wr_q        <= ioctl_wr;
            downl_q     <= ioctl_downl;
            cap_valid_q <= wr_rise;
            if (wr_rise) begin
                cap_q <= '{addr: ioctl_addr, data: ioctl_dout};
            end
        end
    end

    rom_dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_sys),
        .rst_ni    (reset_n),
        .push_i    (cap_valid_q),
        .wr_data_i (cap_q),
        .pop_i     (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Issue FSM: one outstanding request across both ports; port outputs only change in ISSUE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rg_q     <= RG_CPU;
            p1_req_q <= 1'b0;
            p1_a_q   <= '0;
            p1_ds_q  <= '0;
            p1_d_q   <= '0;
            p2_req_q <= 1'b0;
            p2_a_q   <= '0;
            p2_ds_q  <= '0;
            p2_d_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_q   <= fifo_head;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rg_q <= cur_rg;
                    if (cur_rg == RG_CPU) begin
                        p1_a_q   <= cur_q.addr[23:1];
                        p1_ds_q  <= {cur_q.addr[0], ~cur_q.addr[0]};
                        p1_d_q   <= {cur_q.data, cur_q.data};
                        p1_req_q <= ~p1_req_q;
                    end else begin
                        // Bit shuffle lets the sprite ROMs merge into 32-bit words.
                        p2_a_q   <= {s[23:15], s[12:0], s[14]};
                        p2_ds_q  <= {s[13], ~s[13]};
                        p2_d_q   <= {cur_q.data, cur_q.data};
                        p2_req_q <= ~p2_req_q;
                    end
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (issued_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Download start/finish bookkeeping: hold, loaded and overflow flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= 1'b1;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
            drain_q  <= 1'b0;
        end else if (dl_rise) begin
            hold_q   <= 1'b1;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            if (cap_valid_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (dl_fall) begin
                drain_q <= 1'b1;
            end else if (drain_q && drained) begin
                loaded_q <= 1'b1;
                hold_q   <= 1'b0;
                drain_q  <= 1'b0;
            end
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    assign sum_d  = sum_q + {8'd0, cur_q.data};
    assign dl_sum = sum_q;

    // Running sum of bytes that actually reach a port; dropped bytes never get here.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (dl_rise) begin
            sum_q <= '0;
        end else if (state_q == ISSUE) begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Self-checking bench for rom_dl_sequencer: a toggle-ack SDRAM responder
// pops expected port transactions from a scoreboard queue on each request.
module tb_rom_dl_sequencer;

    localparam logic [24:0] SP_BASE = 25'hA000;

    typedef logic [41:0] txn_t;   // {port, a[22:0], ds[1:0], d[15:0]}

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        port1_req, port2_req;
    logic        port1_ack = 1'b0;
    logic        port2_ack = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        rom_hold, rom_loaded, dl_overflow;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] dl_sum;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    txn_t exp_q[$];
    int   ack_dly = 4;
    int   p1_cnt = 0, p2_cnt = 0;
    int   p1_n = 0, p2_n = 0;
    logic p1_seen = 1'b0, p2_seen = 1'b0;

    rom_dl_sequencer dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_d     (port1_d),
        .port2_req   (port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (port2_a),
        .port2_ds    (port2_ds),
        .port2_d     (port2_d),
        .rom_hold    (rom_hold),
        .rom_loaded  (rom_loaded),
        .dl_overflow (dl_overflow)
`ifdef ROM_DL_CHECKSUM_EN
        ,
        .dl_sum      (dl_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-18s got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %-18s 0x%0h", tag, got);
        end
    endtask

    // Reference mapping of one ioctl byte onto a port transaction.
    function automatic txn_t model(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] sv;
        if (a < SP_BASE) return {1'b0, a[23:1], a[0], ~a[0], d, d};
        sv = a - SP_BASE;
        return {1'b1, sv[23:15], sv[12:0], sv[14], sv[13], ~sv[13], d, d};
    endfunction

    task automatic observe(input txn_t t);
        txn_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("txn", t, e);
        end
    endtask

    // SDRAM responder: sees each req toggle, checks it, acks after ack_dly clocks.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            port1_ack = 1'b0; port2_ack = 1'b0;
            p1_seen = 1'b0;   p2_seen = 1'b0;
            p1_cnt = 0;       p2_cnt = 0;
        end else begin
            if (port1_req !== p1_seen) begin
                p1_seen = port1_req; p1_cnt = ack_dly; p1_n++;
                observe({1'b0, port1_a, port1_ds, port1_d});
            end else if (p1_cnt > 0) begin
                p1_cnt--;
                if (p1_cnt == 0) port1_ack = p1_seen;
            end
            if (port2_req !== p2_seen) begin
                p2_seen = port2_req; p2_cnt = ack_dly; p2_n++;
                observe({1'b1, port2_a, port2_ds, port2_d});
            end else if (p2_cnt > 0) begin
                p2_cnt--;
                if (p2_cnt == 0) port2_ack = p2_seen;
            end
        end
    end

    task automatic start_dl();
        @(negedge clk_sys); ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic end_dl();
        @(negedge clk_sys); ioctl_downl = 1'b0;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys); ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        @(negedge clk_sys); ioctl_wr = 1'b0;
    endtask

    task automatic wait_loaded(input int max_clk);
        int n = 0;
        while (rom_loaded !== 1'b1 && n < max_clk) begin
            @(negedge clk_sys); n++;
        end
        chk("rom_loaded", rom_loaded, 1);
        chk("loaded_after_acks", exp_q.size() + int'(p1_cnt > 0) + int'(p2_cnt > 0), 0);
        chk("rom_hold_released", rom_hold, 0);
    endtask

    int b1, b2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_p1_req", port1_req, 0);
        chk("rst_p2_req", port2_req, 0);
        chk("rst_p1_a", {port1_a, port1_ds, port1_d}, 0);
        chk("rst_p2_a", {port2_a, port2_ds, port2_d}, 0);
        chk("rst_hold", rom_hold, 1);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_ovf", dl_overflow, 0);
        reset_n = 1'b1;

        // 0x55 at 0x0001 -> CPU port, word 0, upper byte lane
        b1 = p1_n; b2 = p2_n; ack_dly = 4;
        start_dl();
        chk("dl_hold", rom_hold, 1);
        exp_q.push_back({1'b0, 23'h0, 2'b10, 16'h5555});
        send_byte(25'h0001, 8'h55);
        end_dl();
        wait_loaded(100);
        chk("t1_p1_reqs", p1_n - b1, 1);
        chk("t1_p2_reqs", p2_n - b2, 0);

        // 0xAA at SP_BASE+0x2001 -> sprite port remap
        b1 = p1_n; b2 = p2_n;
        start_dl();
        chk("restart_loaded", rom_loaded, 0);
        exp_q.push_back({1'b1, 23'h2, 2'b10, 16'hAAAA});
        send_byte(25'hC001, 8'hAA);
        end_dl();
        wait_loaded(100);
        chk("t2_p1_reqs", p1_n - b1, 0);
        chk("t2_p2_reqs", p2_n - b2, 1);

        // 12 back-to-back bytes with slow acks: 1 in flight + 8 queued, 3 dropped
        b1 = p1_n; b2 = p2_n; ack_dly = 20;
        start_dl();
        for (int i = 0; i < 12; i++) begin
            logic [24:0] a;
            a = (i % 2 == 1) ? (SP_BASE + 25'(i * 7)) : (25'h0100 + 25'(i));
            if (i < 9) exp_q.push_back(model(a, 8'(8'h30 + i)));
            send_byte(a, 8'(8'h30 + i));
        end
        end_dl();
        repeat (3) @(negedge clk_sys);
        chk("ovf_set", dl_overflow, 1);
        chk("queued_loaded", rom_loaded, 0);
        chk("queued_hold", rom_hold, 1);
        wait_loaded(1000);
        chk("burst_reqs", (p1_n - b1) + (p2_n - b2), 9);
        chk("ovf_sticky", dl_overflow, 1);

        // Zero-byte download; restart clears overflow
        ack_dly = 3;
        start_dl();
        chk("zb_ovf_clr", dl_overflow, 0);
        chk("zb_hold", rom_hold, 1);
        end_dl();
        wait_loaded(6);

        // Reset while a request is outstanding
        ack_dly = 30; b1 = p1_n;
        start_dl();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(25'h0202 + 25'(i), 8'(8'h70 + i)));
            send_byte(25'h0202 + 25'(i), 8'(8'h70 + i));
        end
        for (int n = 0; n < 50 && p1_n == b1; n++) @(negedge clk_sys);
        chk("mid_req_seen", p1_n - b1, 1);
        repeat (3) @(negedge clk_sys);
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        chk("mr_p1_req", port1_req, 0);
        chk("mr_p1_a", {port1_a, port1_ds, port1_d}, 0);
        chk("mr_hold", rom_hold, 1);
        chk("mr_loaded", rom_loaded, 0);
        chk("mr_ovf", dl_overflow, 0);
        chk("mr_sb_left", exp_q.size(), 2);
        exp_q.delete();
        ioctl_downl = 1'b0; ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        ack_dly = 3; b1 = p1_n; b2 = p2_n;
        start_dl();
        exp_q.push_back(model(25'h0010, 8'h11));
        send_byte(25'h0010, 8'h11);
        exp_q.push_back(model(25'hA105, 8'h22));
        send_byte(25'hA105, 8'h22);
        end_dl();
        wait_loaded(200);
        chk("post_rst_reqs", (p1_n - b1) + (p2_n - b2), 2);

`ifdef ROM_DL_CHECKSUM_EN
        start_dl();
        exp_q.push_back(model(25'h0020, 8'hFF)); send_byte(25'h0020, 8'hFF);
        exp_q.push_back(model(25'h0021, 8'hFF)); send_byte(25'h0021, 8'hFF);
        exp_q.push_back(model(25'hA004, 8'h03)); send_byte(25'hA004, 8'h03);
        end_dl();
        wait_loaded(200);
        chk("dl_sum", dl_sum, 16'h0201);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
